// File: rtl/mac_stream_driver_pkg.sv
// Shared constants, cfg field positions and FSM states
// for the mac_cluster stream driver.
package mac_stream_driver_pkg;

  localparam int MAC_CONF_WIDTH = 4;
  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH;
  localparam int MAC_LATENCY    = 2;
  localparam int RES_DEPTH_DEF  = 4;

  localparam int OPW  = 4 * MAC_MIN_WIDTH;
  localparam int OUTW = 4 * MAC_ACC_WIDTH;
  localparam int CFGW = OUTW + MAC_CONF_WIDTH;
  localparam int TAGS = MAC_LATENCY + 1;
  localparam int CNTW = $clog2(TAGS + 1);

  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  localparam int CFG_ACC    = 2;
  localparam int CFG_SIGNED = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic [CNTW-1:0] popcnt(
    input logic [TAGS-1:0] v
  );
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < TAGS; i++) begin
      n = n + CNTW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_stream_driver_if.sv
// Config/operand/result streams plus the cluster-side
// bus, bundled for the driver (slave) and its user (master).
interface mac_stream_driver_if;
  import mac_stream_driver_pkg::*;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CFGW-1:0] cfg_data;

  logic            op_valid;
  logic            op_ready;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic            op_last;

  logic            mac_cset;
  logic            mac_en;
  logic [OPW-1:0]  mac_a;
  logic [OPW-1:0]  mac_b;
  logic [CFGW-1:0] mac_cfg;
  logic [OUTW-1:0] mac_out;

  logic            res_valid;
  logic            res_ready;
  logic [OUTW-1:0] res_data;
  logic            busy;

  modport master (
    output cfg_valid, cfg_data,
    output op_valid, op_a, op_b, op_last,
    output res_ready, mac_out,
    input  cfg_ready, op_ready,
    input  mac_cset, mac_en, mac_a, mac_b, mac_cfg,
    input  res_valid, res_data, busy
  );

  modport slave (
    input  cfg_valid, cfg_data,
    input  op_valid, op_a, op_b, op_last,
    input  res_ready, mac_out,
    output cfg_ready, op_ready,
    output mac_cset, mac_en, mac_a, mac_b, mac_cfg,
    output res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_stream_driver_result_fifo.sv
// Result FIFO: output read from storage registers, so a
// push is never visible in the same cycle it is written.
module mac_stream_driver_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [W-1:0]            data_i,
  input  logic                    pop_i,
  output logic                    valid_o,
  output logic [W-1:0]            data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Push into a full FIFO only coincides with a pop, and
  // then lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mac_stream_driver.sv
// Sequences cset/operands into one mac_cluster and queues
// results of beats tagged last once the pipeline delivers them.
module mac_stream_driver
  import mac_stream_driver_pkg::*;
#(
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  mac_stream_driver_if.slave bus
);

  localparam int FCW = $clog2(RES_DEPTH) + 1;

  state_e          state_q;
  logic [TAGS-1:0] vpipe_q;
  logic [TAGS-1:0] lpipe_q;
  logic            mac_cset_q;
  logic            mac_en_q;
  logic [OPW-1:0]  mac_a_q;
  logic [OPW-1:0]  mac_b_q;
  logic [CFGW-1:0] mac_cfg_q;

  logic [CNTW-1:0] inflight;
  logic [CNTW-1:0] inflight_last;
  logic [FCW-1:0]  fifo_cnt;
  logic            credit_ok;
  logic            cfg_fire;
  logic            op_fire;
  logic            fifo_push;
  logic            fifo_pop;

  assign inflight      = popcnt(vpipe_q);
  assign inflight_last = popcnt(lpipe_q);
  assign credit_ok     =
    (int'(fifo_cnt) + int'(inflight_last)) < RES_DEPTH;

  // Pending cfg blocks operands so the pipe can drain.
  always_comb begin
    bus.cfg_ready = 1'b0;
    bus.op_ready  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: bus.cfg_ready = 1'b1;
        RUN: begin
          bus.cfg_ready = (inflight == '0);
          bus.op_ready  = ~bus.cfg_valid & credit_ok;
        end
        default: ;
      endcase
    end
  end

  assign cfg_fire  = bus.cfg_valid & bus.cfg_ready;
  assign op_fire   = bus.op_valid & bus.op_ready;
  assign fifo_push = lpipe_q[TAGS-1];
  assign fifo_pop  = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vpipe_q    <= '0;
      lpipe_q    <= '0;
      mac_cset_q <= 1'b0;
      mac_en_q   <= 1'b0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_cfg_q  <= '0;
    end else begin
      mac_en_q   <= 1'b1;
      mac_cset_q <= cfg_fire;
      mac_a_q    <= op_fire ? bus.op_a : '0;
      mac_b_q    <= op_fire ? bus.op_b : '0;
      if (cfg_fire) begin
        mac_cfg_q <= bus.cfg_data;
      end
      vpipe_q <= {vpipe_q[TAGS-2:0], op_fire};
      lpipe_q <= {lpipe_q[TAGS-2:0], op_fire & bus.op_last};
      unique case (state_q)
        IDLE:    if (cfg_fire) state_q <= LOAD;
        LOAD:    state_q <= RUN;
        RUN:     if (cfg_fire) state_q <= LOAD;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mac_cset = mac_cset_q;
  assign bus.mac_en   = mac_en_q;
  assign bus.mac_a    = mac_a_q;
  assign bus.mac_b    = mac_b_q;
  assign bus.mac_cfg  = mac_cfg_q;
  assign bus.busy     = (|vpipe_q) | (fifo_cnt != '0);

  mac_stream_driver_result_fifo #(
    .W     (OUTW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (bus.mac_out),
    .pop_i   (fifo_pop),
    .valid_o (bus.res_valid),
    .data_o  (bus.res_data),
    .count_o (fifo_cnt)
  );

endmodule

// File: doc/mac_stream_driver.md
Name: mac_stream_driver

Overview:
- Synthesizable initiator for the `mac_cluster` operand/config interface.
- Accepts config loads and operand beats on valid/ready streams and sequences `cset` and operand presentation into the cluster.
- Tracks the cluster's fixed pipeline latency, captures `out0..out3` for beats tagged `last`, and returns them on a valid/ready result stream.
- Sits between a fabric/DMA-side stream and one `mac_cluster` instance; it is the hardware counterpart of the bench-side driver/checker.

Parameters:
- MAC_CONF_WIDTH, 4, mode field width: [1:0] mode (`MAC_SINGLE`/`MAC_DUAL`/`MAC_QUAD`), [2] accumulate, [3] signed.
- MAC_MIN_WIDTH, 8, per-lane operand width.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, per-lane accumulator/output width.
- MAC_LATENCY, 2, cycles from operands at cluster inputs to result visible on `mac_out`.
- RES_DEPTH, 4, result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config load request.
- cfg_ready  out  1  config accepted when valid&ready.
- cfg_data  in  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  packed as {initial3, initial2, initial1, initial0, mode}.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  operand beat accepted.
- op_a  in  4*MAC_MIN_WIDTH  {A3,A2,A1,A0}.
- op_b  in  4*MAC_MIN_WIDTH  {B3,B2,B1,B0}.
- op_last  in  1  capture the cluster result produced by this beat.
- mac_cset  out  1  to cluster `cset`.
- mac_en  out  1  to cluster `en`.
- mac_a  out  4*MAC_MIN_WIDTH  to cluster A3..A0.
- mac_b  out  4*MAC_MIN_WIDTH  to cluster B3..B0.
- mac_cfg  out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  to cluster `cfg`.
- mac_out  in  4*MAC_ACC_WIDTH  {out3,out2,out1,out0} from cluster.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  4*MAC_ACC_WIDTH  {out3..out0} snapshot.
- busy  out  1  tag pipe non-empty or FIFO non-empty.

Behaviour:
- **Reset values:**
  - mac_cset=0, mac_en=0, mac_a=0, mac_b=0, mac_cfg=0.
  - cfg_ready=0, op_ready=0, res_valid=0, busy=0.
  - Tag pipe cleared; FIFO emptied; state=IDLE.
- **mac_en:** registered; 1 in every cycle after reset deasserts.
- **All mac_* outputs are registered.**
  - Bubble cycles drive mac_a=mac_b=0. This is harmless: accumulate adds 0, and non-accumulate results are never captured.
- **States:**
  - IDLE: no config loaded. op_ready=0. cfg_ready=1.
  - LOAD: one cycle. mac_cset=1; mac_cfg holds the accepted cfg_data. Always goes to RUN next.
  - RUN: op_ready = ~cfg_valid & (fifo_count + inflight_last < RES_DEPTH).
    - cfg_ready = (inflight == 0), i.e. tag pipe drained.
    - A cfg accept goes to LOAD.
- **Priority:** a pending cfg_valid in RUN blocks new operand beats (drain-then-load). With cfg_valid=op_valid=1 and the pipe empty, cfg wins.
- **mac_cfg:** retains the last loaded value throughout RUN; mode bits must stay stable while the cluster computes.
- **Tag pipe:**
  - Shift register of MAC_LATENCY+1 stages; bit = accepted & op_last.
  - On tag exit, write mac_out into the FIFO.
  - `inflight` counts occupied stages of any beat; `inflight_last` counts last-tags.
- **Latency:** beat accepted in cycle n → res_valid earliest in cycle n+MAC_LATENCY+2 (n+4 at default), given an empty FIFO.
- **Back-to-back:** one beat per cycle sustained while FIFO credit exists.
  - The credit check guarantees a FIFO write never finds the FIFO full; no result is ever dropped.
- **FIFO:**
  - Registered output, not fall-through.
  - Simultaneous push/pop when full is legal, since credit prevents a push into a truly full FIFO.
  - Pop on res_valid & res_ready. res_data is stable while res_valid & ~res_ready.
- **Reset mid-operation:** in-flight beats and queued results are discarded; the next cycle behaves as the first post-reset cycle.
- **Arithmetic:** none in this block. Widths pass through unchanged; signed/dual/quad semantics belong to the cluster.

Decomposition:
- Shared include (`mac_const.vh`): `MAC_SINGLE`/`MAC_DUAL`/`MAC_QUAD` encodings, cfg bit positions (ACC=2, SIGNED=3), state encodings for IDLE/LOAD/RUN.
- One sub-module: `mac_result_fifo` (parameterized width/depth, registered output, count output).
- Tag pipe and FSM stay in the top.

Test Plan:
- **Reset/idle:** rst high 3 cycles → all outputs 0; after release mac_en=1, cfg_ready=1, op_ready=0.
- **Accumulate:** load cfg mode=SINGLE, acc=1, unsigned, initial0=5 → mac_cset high exactly one cycle.
  - Beats (A0=3,B0=4,last=0) then (A0=2,B0=2,last=1) → single result, out0 field = 21, res_valid 4 cycles after the second accept.
- **Signed non-accumulate:** SINGLE, signed=1, acc=0, A0=8'hFF, B0=8'h02, last=1 → res_data[31:0] = 32'hFFFFFFFE.
- **Backpressure:** res_ready=0, stream 6 last-beats with RES_DEPTH=4 → op_ready drops after the 4th accept.
  - Release res_ready → all 6 results delivered in order, none lost or duplicated.
- **Config vs. operands:** cfg_valid asserted while 2 beats are in flight → op_ready=0 immediately; cset issued only after the pipe empties.
  - Subsequent accumulate starts from the new initial values.
- **Reset mid-stream:** rst pulsed with 2 results queued and 1 in flight → res_valid=0 next cycle, state IDLE, no stale result emitted afterward.
